rrf_commit_ctrl: RTL and testbench
==================================

Name: rrf_commit_ctrl

Overview:
- Sequences ROB commits into the single-write-port retirement register file (RRF).
- Accepts up to two commits per cycle into a small in-order buffer and retires one per cycle: RRF write plus free-list enqueue of the displaced physical register.
- On flush, drains accepted commits, then walks the RRF to restore the front-end RAT.
- Sits between ROB head, RRF, free list and RAT.

Parameters:
- PHYS_REG_BITS, 6, physical register index width
- ARCH_REG_BITS, 5, architectural register index width
- BUF_DEPTH, 4, commit buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- commit_valid  in  2  ROB head lanes ready to commit (lane0 older)
- commit_regf_we  in  2  lane writes a register
- commit_rd  in  2x5  lane architectural destination
- commit_pd  in  2x6  lane new physical register
- commit_accept  out  2  lanes taken this cycle (combinational)
- rrf_regf_we  out  1  RRF write enable
- rrf_rd  out  5  RRF write/lookup index
- rrf_pd  out  6  RRF write data
- rrf_old_pd  in  6  RRF's current mapping of rrf_rd (combinational read)
- fl_enq  out  1  free-list push
- fl_pd  out  6  physical register freed
- fl_full  in  1  free list cannot accept
- flush_req  in  1  pipeline flush request (level, sampled)
- rrf_rd_idx  out  5  RRF read index during restore
- rrf_rd_pd  in  6  RRF mapping at rrf_rd_idx
- rat_restore_we  out  1  RAT restore write
- rat_restore_rd  out  5  RAT restore index
- rat_restore_pd  out  6  RAT restore data
- flush_done  out  1  one-cycle pulse, restore complete
- busy  out  1  buffer non-empty or state != RUN

Behaviour:
- Reset (rst=0 at posedge): buffer empty, pointers/count 0, state RUN. All outputs 0.
- States: RUN, DRAIN, RESTORE, DONE.
- Accept (RUN only): accept[0] = valid[0] && free>=1; accept[1] = accept[0] && valid[1] && free>=2. Free = BUF_DEPTH - registered count; same-cycle pop not credited. Never accept lane1 without lane0. In all other states commit_accept = 0.
- Accepted lanes are written in order (lane0 first) at the posedge.
- Retire (RUN or DRAIN, buffer non-empty), head entry per cycle:
  - we=0 or rd=0: pop; no RRF write, no fl_enq.
  - we=1, rd!=0, fl_full=0: rrf_regf_we=1, rrf_rd=rd, rrf_pd=pd, fl_enq=1, fl_pd=rrf_old_pd, pop.
  - we=1, rd!=0, fl_full=1: stall; all write/enq outputs 0; head retained.
- Latency: accepted entry retires no earlier than the cycle after acceptance. At most one retire per cycle.
- Same-rd commits back to back are correct: each retire sees the previous cycle's RRF write.
- Full buffer with simultaneous pop: no accept that cycle.
- Flush:
  - flush_req=1 in RUN: this cycle's accept is suppressed; next state DRAIN. Already-accepted entries are architecturally committed and still retire.
  - DRAIN: when count reaches 0, go to RESTORE with idx=1.
  - RESTORE: each cycle rrf_rd_idx=idx, rat_restore_we=1, rat_restore_rd=idx, rat_restore_pd=rrf_rd_pd. idx runs 1..31 (31 cycles, x0 skipped), then DONE.
  - DONE: flush_done=1 for one cycle, then RUN.
  - flush_req is ignored outside RUN.
- Pointer wrap modulo BUF_DEPTH. Count is ARCH-independent, width clog2(BUF_DEPTH)+1.
- Reset mid-DRAIN/RESTORE: abort immediately; flush_done never asserted; buffer cleared.

Optional Feature:
- Macro: RRF_COMMIT_BYPASS_EN
- Defined: in RUN with buffer empty and fl_full=0, an accepted lane0 retires in the same cycle directly from the commit ports (not enqueued); lane1, if accepted, enters the buffer. Zero-cycle retire latency.
- Undefined: all accepted lanes pass through the buffer; minimum latency 1 cycle.

Test Plan:
- Reset, then lane0 {we=1,rd=1,pd=32} with rrf_old_pd=1 -> next cycle rrf_regf_we=1, rrf_rd=1, rrf_pd=32, fl_enq=1, fl_pd=1.
- Both lanes valid {rd=2,pd=51},{rd=2,pd=56} -> accept=2'b11; retires on consecutive cycles; second fl_pd equals 51 (first write's pd).
- Lane {we=1,rd=0,pd=5} and lane {we=0,rd=17,pd=1} -> both popped; rrf_regf_we and fl_enq stay 0.
- Hold fl_full=1 for 3 cycles with 4 entries queued -> no retires, accept=0; fl_full=0 -> 4 retires on 4 consecutive cycles, order preserved.
- flush_req with 2 entries buffered -> 2 retires, then 31 restore writes idx 1..31 with pd equal to RRF contents, then one flush_done pulse, then accept resumes.
- rst=0 at restore idx=10 -> all outputs 0 next cycle, no flush_done, state RUN.

Source files
------------

// File: rtl/rrf_commit_ctrl_if.sv
// +---------------------------------------------------------------------------+
// | rrf_commit_ctrl_if : ROB/RRF/free-list/RAT signal bundle of rrf_commit_ctrl |
// | Rev 1.0                                                                     |
// +---------------------------------------------------------------------------+
`default_nettype none

interface rrf_commit_ctrl_if #(
   parameter int PHYS_REG_BITS = 6,
   parameter int ARCH_REG_BITS = 5
);
   logic [1:0]                        commit_valid;
   logic [1:0]                        commit_regf_we;
   logic [1:0][ARCH_REG_BITS-1:0]     commit_rd;
   logic [1:0][PHYS_REG_BITS-1:0]     commit_pd;
   logic [1:0]                        commit_accept;
   logic                              rrf_regf_we;
   logic [ARCH_REG_BITS-1:0]          rrf_rd;
   logic [PHYS_REG_BITS-1:0]          rrf_pd;
   logic [PHYS_REG_BITS-1:0]          rrf_old_pd;
   logic                              fl_enq;
   logic [PHYS_REG_BITS-1:0]          fl_pd;
   logic                              fl_full;
   logic                              flush_req;
   logic [ARCH_REG_BITS-1:0]          rrf_rd_idx;
   logic [PHYS_REG_BITS-1:0]          rrf_rd_pd;
   logic                              rat_restore_we;
   logic [ARCH_REG_BITS-1:0]          rat_restore_rd;
   logic [PHYS_REG_BITS-1:0]          rat_restore_pd;
   logic                              flush_done;
   logic                              busy;

   modport master (
      output commit_valid, commit_regf_we, commit_rd, commit_pd, rrf_old_pd,
             fl_full, flush_req, rrf_rd_pd,
      input  commit_accept, rrf_regf_we, rrf_rd, rrf_pd, fl_enq, fl_pd,
             rrf_rd_idx, rat_restore_we, rat_restore_rd, rat_restore_pd,
             flush_done, busy
   );

   modport slave (
      input  commit_valid, commit_regf_we, commit_rd, commit_pd, rrf_old_pd,
             fl_full, flush_req, rrf_rd_pd,
      output commit_accept, rrf_regf_we, rrf_rd, rrf_pd, fl_enq, fl_pd,
             rrf_rd_idx, rat_restore_we, rat_restore_rd, rat_restore_pd,
             flush_done, busy
   );
endinterface

`default_nettype wire

// File: rtl/rrf_commit_ctrl.sv
// +---------------------------------------------------------------------------+
// | rrf_commit_ctrl : in-order commit buffer, RRF retire, flush RAT restore     |
// | Optional macro RRF_COMMIT_BYPASS_EN: zero-latency lane0 retire when empty   |
// | Rev 1.0                                                                     |
// +---------------------------------------------------------------------------+
`default_nettype none

module rrf_commit_ctrl #(
   parameter int PHYS_REG_BITS = 6,
   parameter int ARCH_REG_BITS = 5,
   parameter int BUF_DEPTH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   rrf_commit_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]         c_depth    = CNT_W'(BUF_DEPTH);
   localparam logic [ARCH_REG_BITS-1:0] c_idx_last = '1;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_DRAIN   = 2'd1,
      S_RESTORE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [ARCH_REG_BITS-1:0] idx_q, idx_d;

   logic                     buf_we_q [BUF_DEPTH];
   logic [ARCH_REG_BITS-1:0] buf_rd_q [BUF_DEPTH];
   logic [PHYS_REG_BITS-1:0] buf_pd_q [BUF_DEPTH];

   logic [CNT_W-1:0]         w_free;
   logic                     w_acc0, w_acc1, w_push0, w_push1, w_pop, w_bypass;
   logic                     w_head_writes;
   logic [PTR_W-1:0]         w_tail1;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      w_acc0   = 1'b0;
      w_acc1   = 1'b0;
      w_pop    = 1'b0;
      w_bypass = 1'b0;
      bus.commit_accept  = '0;
      bus.rrf_regf_we    = 1'b0;
      bus.rrf_rd         = '0;
      bus.rrf_pd         = '0;
      bus.fl_enq         = 1'b0;
      bus.fl_pd          = '0;
      bus.rrf_rd_idx     = '0;
      bus.rat_restore_we = 1'b0;
      bus.rat_restore_rd = '0;
      bus.rat_restore_pd = '0;
      bus.flush_done     = 1'b0;
      w_free        = c_depth - count_q;
      w_head_writes = buf_we_q[head_q] && (buf_rd_q[head_q] != '0);

      unique case (state_q)
         S_RUN: begin
            // Free space is judged on the registered count; a same-cycle pop is not credited.
            if (rst && !bus.flush_req) begin
               w_acc0 = bus.commit_valid[0] && (w_free >= CNT_W'(1));
               w_acc1 = w_acc0 && bus.commit_valid[1] && (w_free >= CNT_W'(2));
            end
            if (bus.flush_req) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (count_q == '0) begin
               state_d = S_RESTORE;
               idx_d   = ARCH_REG_BITS'(1);
            end
         end
         S_RESTORE: begin
            bus.rrf_rd_idx     = idx_q;
            bus.rat_restore_we = 1'b1;
            bus.rat_restore_rd = idx_q;
            bus.rat_restore_pd = bus.rrf_rd_pd;
            if (idx_q == c_idx_last) state_d = S_DONE;
            else                     idx_d   = idx_q + ARCH_REG_BITS'(1);
         end
         S_DONE: begin
            bus.flush_done = 1'b1;
            state_d        = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
      bus.commit_accept = {w_acc1, w_acc0};

      if ((state_q == S_RUN || state_q == S_DRAIN) && count_q != '0) begin
         if (!w_head_writes) begin
            w_pop = 1'b1;
         end else if (!bus.fl_full) begin
            bus.rrf_regf_we = 1'b1;
            bus.rrf_rd      = buf_rd_q[head_q];
            bus.rrf_pd      = buf_pd_q[head_q];
            bus.fl_enq      = 1'b1;
            bus.fl_pd       = bus.rrf_old_pd;
            w_pop           = 1'b1;
         end
      end
`ifdef RRF_COMMIT_BYPASS_EN
      else if (state_q == S_RUN && w_acc0 && !bus.fl_full) begin
         w_bypass = 1'b1;
         if (bus.commit_regf_we[0] && bus.commit_rd[0] != '0) begin
            bus.rrf_regf_we = 1'b1;
            bus.rrf_rd      = bus.commit_rd[0];
            bus.rrf_pd      = bus.commit_pd[0];
            bus.fl_enq      = 1'b1;
            bus.fl_pd       = bus.rrf_old_pd;
         end
      end
`endif

      w_push0 = w_acc0 && !w_bypass;
      w_push1 = w_acc1;
      w_tail1 = tail_q + PTR_W'(w_push0);
      tail_d  = w_tail1 + PTR_W'(w_push1);
      head_d  = head_q + PTR_W'(w_pop);
      count_d = count_q + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
      bus.busy = (count_q != '0) || (state_q != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   // Payload needs no reset: count_q alone defines which slots are live.
   always_ff @(posedge clk) begin
      if (w_push0) begin
         buf_we_q[tail_q] <= bus.commit_regf_we[0];
         buf_rd_q[tail_q] <= bus.commit_rd[0];
         buf_pd_q[tail_q] <= bus.commit_pd[0];
      end
      if (w_push1) begin
         buf_we_q[w_tail1] <= bus.commit_regf_we[1];
         buf_rd_q[w_tail1] <= bus.commit_rd[1];
         buf_pd_q[w_tail1] <= bus.commit_pd[1];
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_rrf_commit_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_rrf_commit_ctrl : randomized bench with queue-based reference model      |
// | Rev 1.0                                                                     |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_rrf_commit_ctrl;
   localparam int PRB   = 6;
   localparam int ARB   = 5;
   localparam int DEPTH = 4;
   localparam int M_RUN = 0, M_DRAIN = 1, M_RESTORE = 2, M_DONE = 3;

   typedef struct packed {
      logic           we;
      logic [ARB-1:0] rd;
      logic [PRB-1:0] pd;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rrf_commit_ctrl_if #(.PHYS_REG_BITS(PRB), .ARCH_REG_BITS(ARB)) ifc ();

   rrf_commit_ctrl #(
      .PHYS_REG_BITS(PRB),
      .ARCH_REG_BITS(ARB),
      .BUF_DEPTH    (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   logic [PRB-1:0] rrf_mem [32];
   assign ifc.rrf_old_pd = rrf_mem[ifc.rrf_rd];
   assign ifc.rrf_rd_pd  = rrf_mem[ifc.rrf_rd_idx];

   ent_t q[$];
   int   mst;
   int   midx;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] v, input ent_t a, input ent_t b);
      ifc.commit_valid      = v;
      ifc.commit_regf_we[0] = a.we;
      ifc.commit_rd[0]      = a.rd;
      ifc.commit_pd[0]      = a.pd;
      ifc.commit_regf_we[1] = b.we;
      ifc.commit_rd[1]      = b.rd;
      ifc.commit_pd[1]      = b.pd;
   endtask

   task automatic idle();
      drive(2'b00, '0, '0);
   endtask

   // One clock cycle: predict outputs from the model, compare, then advance the model.
   task automatic step();
      int             n_acc;
      bit             pop, byp;
      ent_t           l0, l1;
      logic           e_we, e_enq, e_rat, e_done, e_busy;
      logic [ARB-1:0] e_rd, e_ridx;
      logic [PRB-1:0] e_pd, e_flpd, e_rpd;
      int             nst;
      #1;
      l0 = '{ifc.commit_regf_we[0], ifc.commit_rd[0], ifc.commit_pd[0]};
      l1 = '{ifc.commit_regf_we[1], ifc.commit_rd[1], ifc.commit_pd[1]};
      n_acc = 0;
      if (mst == M_RUN && !ifc.flush_req && ifc.commit_valid[0] && q.size() < DEPTH) begin
         n_acc = (ifc.commit_valid[1] && q.size() < DEPTH - 1) ? 2 : 1;
      end
      pop = 0; byp = 0;
      e_we = 0; e_enq = 0; e_rd = 0; e_pd = 0; e_flpd = 0;
      if ((mst == M_RUN || mst == M_DRAIN) && q.size() > 0) begin
         if (q[0].we && q[0].rd != 0) begin
            if (!ifc.fl_full) begin
               e_we = 1; e_enq = 1; e_rd = q[0].rd; e_pd = q[0].pd;
               e_flpd = rrf_mem[q[0].rd]; pop = 1;
            end
         end else begin
            pop = 1;
         end
      end
`ifdef RRF_COMMIT_BYPASS_EN
      else if (mst == M_RUN && q.size() == 0 && n_acc > 0 && !ifc.fl_full) begin
         byp = 1;
         if (l0.we && l0.rd != 0) begin
            e_we = 1; e_enq = 1; e_rd = l0.rd; e_pd = l0.pd; e_flpd = rrf_mem[l0.rd];
         end
      end
`endif
      e_rat  = (mst == M_RESTORE);
      e_ridx = e_rat ? ARB'(midx) : '0;
      e_rpd  = e_rat ? rrf_mem[midx] : '0;
      e_done = (mst == M_DONE);
      e_busy = (q.size() > 0) || (mst != M_RUN);

      check("accept",      ifc.commit_accept, (n_acc == 2) ? 2'b11 : (n_acc == 1) ? 2'b01 : 2'b00);
      check("rrf_we",      ifc.rrf_regf_we, e_we);
      check("rrf_rd",      ifc.rrf_rd, e_rd);
      check("rrf_pd",      ifc.rrf_pd, e_pd);
      check("fl_enq",      ifc.fl_enq, e_enq);
      check("fl_pd",       ifc.fl_pd, e_flpd);
      check("rrf_rd_idx",  ifc.rrf_rd_idx, e_ridx);
      check("rat_we",      ifc.rat_restore_we, e_rat);
      check("rat_rd",      ifc.rat_restore_rd, e_ridx);
      check("rat_pd",      ifc.rat_restore_pd, e_rpd);
      check("flush_done",  ifc.flush_done, e_done);
      check("busy",        ifc.busy, e_busy);

      nst = mst;
      case (mst)
         M_RUN:     if (ifc.flush_req) nst = M_DRAIN;
         M_DRAIN:   if (q.size() == 0) begin nst = M_RESTORE; midx = 1; end
         M_RESTORE: if (midx == 31) nst = M_DONE; else midx++;
         default:   nst = M_RUN;
      endcase
      @(posedge clk);
      if (e_we) rrf_mem[e_rd] = e_pd;
      if (pop) void'(q.pop_front());
      if (n_acc >= 1 && !byp) q.push_back(l0);
      if (n_acc == 2) q.push_back(l1);
      mst = nst;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      ifc.fl_full   = 1'b0;
      ifc.flush_req = 1'b0;
      @(posedge clk);
      q.delete();
      mst  = M_RUN;
      midx = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rrf_mem[i] = PRB'(i);
      do_reset();
      step();
      step();

      // Single write commit, then same-rd pair back to back.
      drive(2'b01, '{1'b1, 5'd1, 6'd32}, '0); step();
      idle(); step(); step();
      drive(2'b11, '{1'b1, 5'd2, 6'd51}, '{1'b1, 5'd2, 6'd56}); step();
      idle(); step(); step(); step();

      // Non-writing commits: rd=0 and we=0.
      drive(2'b11, '{1'b1, 5'd0, 6'd5}, '{1'b0, 5'd17, 6'd1}); step();
      idle(); step(); step(); step();

      // Free list full: fill buffer, hold, then release.
      ifc.fl_full = 1'b1;
      drive(2'b11, '{1'b1, 5'd3, 6'd40}, '{1'b1, 5'd4, 6'd41}); step();
      drive(2'b11, '{1'b1, 5'd5, 6'd42}, '{1'b1, 5'd6, 6'd43}); step();
      drive(2'b11, '{1'b1, 5'd7, 6'd44}, '{1'b1, 5'd8, 6'd45});
      for (int k = 0; k < 3; k++) step();
      idle();
      ifc.fl_full = 1'b0;
      for (int k = 0; k < 6; k++) step();

      // Flush with two entries buffered, then resume.
      ifc.fl_full = 1'b1;
      drive(2'b11, '{1'b1, 5'd9, 6'd60}, '{1'b1, 5'd10, 6'd61}); step();
      idle();
      ifc.fl_full   = 1'b0;
      ifc.flush_req = 1'b1; step();
      ifc.flush_req = 1'b0;
      for (int k = 0; k < 40; k++) step();
      drive(2'b01, '{1'b1, 5'd11, 6'd62}, '0); step();
      idle(); step(); step();

      // Randomized traffic.
      for (int k = 0; k < 2500; k++) begin
         ent_t a, b;
         a = '{($urandom_range(0, 4) != 0), ARB'($urandom_range(0, 31)), PRB'($urandom)};
         b = '{($urandom_range(0, 4) != 0), ARB'($urandom_range(0, 31)), PRB'($urandom)};
         drive(2'($urandom), a, b);
         ifc.fl_full   = ($urandom_range(0, 3) == 0);
         ifc.flush_req = ($urandom_range(0, 60) == 0);
         step();
      end
      idle();
      ifc.fl_full   = 1'b0;
      ifc.flush_req = 1'b0;
      for (int k = 0; k < 45; k++) step();

      // Reset while restoring at idx 10.
      ifc.flush_req = 1'b1; step();
      ifc.flush_req = 1'b0;
      for (int k = 0; k < 100 && !(mst == M_RESTORE && midx == 10); k++) step();
      check("restore_idx10", ifc.rrf_rd_idx, 10);
      do_reset();
      check("rst_busy",  ifc.busy, 0);
      check("rst_rat_we", ifc.rat_restore_we, 0);
      for (int k = 0; k < 40; k++) step();
      drive(2'b01, '{1'b1, 5'd12, 6'd63}, '0); step();
      idle(); step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
